// File: rtl/spu_pipe_stage_elastic.sv
// Elastic LANES-wide SPU stage register: ready/valid handshake with a 2-entry skid buffer,
// per-lane valid and synchronous flush. Define SPU_STAGE_PERF_EN to add stall/bubble counters.
module spu_pipe_stage_elastic #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 128,
  parameter int RADDR_W = 7,
  parameter int CTRL_W  = 4,
  parameter int IMM_W   = 51
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_lane_valid,
  input  logic [LANES-1:0]           in_regWriteEnable,
  input  logic [LANES-1:0]           in_source,
  input  logic [LANES*CTRL_W-1:0]    in_control,
  input  logic [LANES*DATA_W-1:0]    in_readDataRA,
  input  logic [LANES*DATA_W-1:0]    in_readDataRB,
  input  logic [LANES*DATA_W-1:0]    in_readDataRC,
  input  logic [LANES*RADDR_W-1:0]   in_readRegisterRA,
  input  logic [LANES*RADDR_W-1:0]   in_readRegisterRB,
  input  logic [LANES*IMM_W-1:0]     in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_lane_valid,
  output logic [LANES-1:0]           out_regWriteEnable,
  output logic [LANES-1:0]           out_source,
  output logic [LANES*CTRL_W-1:0]    out_control,
  output logic [LANES*DATA_W-1:0]    out_readDataRA,
  output logic [LANES*DATA_W-1:0]    out_readDataRB,
  output logic [LANES*DATA_W-1:0]    out_readDataRC,
  output logic [LANES*RADDR_W-1:0]   out_readRegisterRA,
  output logic [LANES*RADDR_W-1:0]   out_readRegisterRB,
  output logic [LANES*IMM_W-1:0]     out_imm
`ifdef SPU_STAGE_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [LANES-1:0]         lv;
    logic [LANES-1:0]         we;
    logic [LANES-1:0]         src;
    logic [LANES*CTRL_W-1:0]  ctrl;
    logic [LANES*DATA_W-1:0]  ra;
    logic [LANES*DATA_W-1:0]  rb;
    logic [LANES*DATA_W-1:0]  rc;
    logic [LANES*RADDR_W-1:0] rra;
    logic [LANES*RADDR_W-1:0] rrb;
    logic [LANES*IMM_W-1:0]   imm;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, in_e;
  logic   in_fire, out_fire, cap;

  assign in_ready  = !reset && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // A bundle with no live lane is swallowed without occupying an entry.
  assign cap       = in_fire & (|in_lane_valid);

  always_comb begin
    in_e      = '0;
    in_e.lv   = in_lane_valid;
    in_e.we   = in_regWriteEnable & in_lane_valid;
    in_e.src  = in_source;
    in_e.ctrl = in_control;
    in_e.ra   = in_readDataRA;
    in_e.rb   = in_readDataRB;
    in_e.rc   = in_readDataRC;
    in_e.rra  = in_readRegisterRA;
    in_e.rrb  = in_readRegisterRB;
    in_e.imm  = in_imm;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (cap) begin
        state_d = ONE;
        main_d  = in_e;
      end
      ONE: begin
        if (cap && out_fire) begin
          main_d = in_e;
        end else if (cap) begin
          state_d = TWO;
          skid_d  = in_e;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // Flush kills lane validity only; operand payload is left as-is.
    if (flush) begin
      state_d   = EMPTY;
      main_d    = main_q;
      skid_d    = skid_q;
      main_d.lv = '0;
      main_d.we = '0;
      skid_d.lv = '0;
      skid_d.we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_lane_valid     = main_q.lv & {LANES{out_valid}};
  assign out_regWriteEnable = main_q.we & {LANES{out_valid}};
  assign out_source         = main_q.src;
  assign out_control        = main_q.ctrl;
  assign out_readDataRA     = main_q.ra;
  assign out_readDataRB     = main_q.rb;
  assign out_readDataRC     = main_q.rc;
  assign out_readRegisterRA = main_q.rra;
  assign out_readRegisterRB = main_q.rrb;
  assign out_imm            = main_q.imm;

`ifdef SPU_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!out_valid && bubble_cnt_q != 32'hFFFF_FFFF)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
